zueirai_gpio: RTL and testbench

Parametrised GPIO controller for the ZueiraI core, generalising the fixed three-port, 8-bit tri-state block to NPORTS ports of WIDTH bits. The controller adds per-port output, direction and toggle registers on a simple register bus, input synchronisers, and per-bit edge-detect interrupt flags with a combined IRQ. It sits between the core's I/O register bus and the chip pads.

---
 rtl/zueirai_gpio_if.sv | 29 ++
 rtl/zueirai_gpio.sv | 155 +++++++++++++++
 tb/tb_zueirai_gpio.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zueirai_gpio_if.sv
`default_nettype none
// ============================================================================
// Module   : zueirai_gpio_if
// Brief    : Register-bus bundle between the core and the GPIO controller.
// Revision : 1.0 - initial release
// ============================================================================
interface zueirai_gpio_if #(
    parameter int AW    = 5,
    parameter int WIDTH = 8
);
    logic [AW-1:0]    ADDR;
    logic [WIDTH-1:0] WDATA;
    logic             WE;
    logic             RE;
    logic [WIDTH-1:0] RDATA;
    logic             RVALID;
    logic             IRQ;

    modport master (
        output ADDR, WDATA, WE, RE,
        input  RDATA, RVALID, IRQ
    );

    modport slave (
        input  ADDR, WDATA, WE, RE,
        output RDATA, RVALID, IRQ
    );
endinterface
`default_nettype wire

// File: rtl/zueirai_gpio.sv
`default_nettype none
// ============================================================================
// Module   : zueirai_gpio
// Brief    : NPORTS x WIDTH tri-state GPIO with synchronised inputs and
//            per-bit edge interrupts behind a simple register bus.
// Revision : 1.0 - initial release
// ============================================================================
module zueirai_gpio #(
    parameter int NPORTS      = 3,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AW          = $clog2(NPORTS*8)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    zueirai_gpio_if.slave             bus,
    inout  wire [NPORTS*WIDTH-1:0]    PORT
);

    localparam int PW = (AW > 3) ? AW - 3 : 1;
    localparam int NB = NPORTS * WIDTH;
    localparam int CW = $clog2(SYNC_STAGES + 2);

    localparam logic [CW-1:0] C_PRIME_DONE = CW'(SYNC_STAGES + 1);
    localparam logic [PW:0]   C_NPORTS     = (PW+1)'(NPORTS);

    localparam logic [2:0] C_REG_OUT    = 3'd0;
    localparam logic [2:0] C_REG_DIR    = 3'd1;
    localparam logic [2:0] C_REG_PIN    = 3'd2;
    localparam logic [2:0] C_REG_IE     = 3'd3;
    localparam logic [2:0] C_REG_EDGE   = 3'd4;
    localparam logic [2:0] C_REG_IFLAG  = 3'd5;
    localparam logic [2:0] C_REG_TOGGLE = 3'd6;

    typedef logic [NPORTS-1:0][WIDTH-1:0] port_arr_t;

    port_arr_t                   r_out;
    port_arr_t                   r_dir;
    port_arr_t                   r_ie;
    port_arr_t                   r_edge;
    port_arr_t                   r_iflag;
    logic [SYNC_STAGES-1:0][NB-1:0] r_sync;
    logic [NB-1:0]               r_prev;
    logic [CW-1:0]               r_prime;
    logic [WIDTH-1:0]            r_rdata;
    logic                        r_rvalid;

    port_arr_t                   w_pin;
    port_arr_t                   w_prevp;
    port_arr_t                   w_set;
    port_arr_t                   w_clr;
    logic [NB-1:0]               w_dir_flat;
    logic [NB-1:0]               w_out_flat;
    logic [PW-1:0]               w_pidx;
    logic [2:0]                  w_reg;
    logic                        w_port_ok;
    logic                        w_wr;
    logic                        w_armed;
    logic [WIDTH-1:0]            w_rdata;

    // Single-port configurations have no port field in the address.
    generate
        if (AW > 3) begin : g_pidx_field
            assign w_pidx = bus.ADDR[AW-1:3];
        end else begin : g_pidx_none
            assign w_pidx = '0;
        end
    endgenerate

    assign w_reg     = bus.ADDR[2:0];
    assign w_port_ok = ({1'b0, w_pidx} < C_NPORTS);
    assign w_wr      = bus.WE & w_port_ok;

    assign w_pin   = r_sync[SYNC_STAGES-1];
    assign w_prevp = r_prev;
    assign w_armed = (r_prime == C_PRIME_DONE);

    // Edges are held off until the synchroniser and delay stage hold real pad data.
    assign w_set = w_armed ? ((r_edge & w_prevp & ~w_pin) | (~r_edge & w_pin & ~w_prevp))
                           : '0;

    always_comb begin
        w_clr = '0;
        if (w_wr && (w_reg == C_REG_IFLAG)) begin
            w_clr[w_pidx] = bus.WDATA;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_port_ok) begin
            case (w_reg)
                C_REG_OUT:   w_rdata = r_out[w_pidx];
                C_REG_DIR:   w_rdata = r_dir[w_pidx];
                C_REG_PIN:   w_rdata = w_pin[w_pidx];
                C_REG_IE:    w_rdata = r_ie[w_pidx];
                C_REG_EDGE:  w_rdata = r_edge[w_pidx];
                C_REG_IFLAG: w_rdata = r_iflag[w_pidx];
                default:     w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_ie     <= '0;
            r_edge   <= '0;
            r_iflag  <= '0;
            r_sync   <= '0;
            r_prev   <= '0;
            r_prime  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], PORT};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (!w_armed) begin
                r_prime <= r_prime + CW'(1);
            end
            // A new edge wins over a simultaneous write-1-to-clear.
            r_iflag  <= (r_iflag & ~w_clr) | w_set;
            r_rvalid <= bus.RE;
            if (bus.RE) begin
                r_rdata <= w_rdata;
            end
            if (w_wr) begin
                case (w_reg)
                    C_REG_OUT:    r_out[w_pidx]  <= bus.WDATA;
                    C_REG_DIR:    r_dir[w_pidx]  <= bus.WDATA;
                    C_REG_IE:     r_ie[w_pidx]   <= bus.WDATA;
                    C_REG_EDGE:   r_edge[w_pidx] <= bus.WDATA;
                    C_REG_TOGGLE: r_out[w_pidx]  <= r_out[w_pidx] ^ bus.WDATA;
                    default:      ;
                endcase
            end
        end
    end

    assign bus.RDATA  = r_rdata;
    assign bus.RVALID = r_rvalid;
    assign bus.IRQ    = |(r_iflag & r_ie);

    assign w_dir_flat = r_dir;
    assign w_out_flat = r_out;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_pad
            assign PORT[gi] = w_dir_flat[gi] ? w_out_flat[gi] : 1'bz;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_zueirai_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tb_zueirai_gpio
// Brief    : Directed self-checking bench for zueirai_gpio with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zueirai_gpio;

    localparam int NP = 3;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int AW = $clog2(NP*8);
    localparam int NB = NP * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zueirai_gpio_if #(.AW(AW), .WIDTH(W)) bus ();

    wire  [NB-1:0] pads;
    logic [NB-1:0] ext_en;
    logic [NB-1:0] ext_val;

    for (genvar gi = 0; gi < NB; gi++) begin : g_ext
        assign pads[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
    end

    zueirai_gpio #(.NPORTS(NP), .WIDTH(W), .SYNC_STAGES(S), .AW(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .PORT (pads)
    );

    // Reference model: register file plus a history of sampled pad values.
    logic [W-1:0]  m_out   [NP];
    logic [W-1:0]  m_dir   [NP];
    logic [W-1:0]  m_ie    [NP];
    logic [W-1:0]  m_edge  [NP];
    logic [W-1:0]  m_iflag [NP];
    logic [NB-1:0] hist    [0:S];
    int            m_cnt;
    logic [W-1:0]  exp_rdata;
    logic          exp_rvalid;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < NP; q++) begin
            m_out[q] = '0; m_dir[q] = '0; m_ie[q] = '0; m_edge[q] = '0; m_iflag[q] = '0;
        end
        for (int k = 0; k <= S; k++) hist[k] = '0;
        m_cnt      = 0;
        exp_rdata  = '0;
        exp_rvalid = 1'b0;
    endtask

    function automatic logic [NB-1:0] m_flat_dir();
        logic [NB-1:0] v;
        v = '0;
        for (int q = 0; q < NP; q++) v[q*W +: W] = m_dir[q];
        return v;
    endfunction

    function automatic logic [NB-1:0] m_flat_out();
        logic [NB-1:0] v;
        v = '0;
        for (int q = 0; q < NP; q++) v[q*W +: W] = m_out[q];
        return v;
    endfunction

    function automatic logic m_irq();
        logic v;
        v = 1'b0;
        for (int q = 0; q < NP; q++) v = v | (|(m_iflag[q] & m_ie[q]));
        return v;
    endfunction

    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
        int p;
        p = int'(a[AW-1:3]);
        if (p >= NP) return '0;
        case (int'(a[2:0]))
            0:       return m_out[p];
            1:       return m_dir[p];
            2:       return hist[S-1][p*W +: W];
            3:       return m_ie[p];
            4:       return m_edge[p];
            5:       return m_iflag[p];
            default: return '0;
        endcase
    endfunction

    task automatic model_update();
        logic [NB-1:0] pad_now;
        logic [W-1:0]  setv, clrv, pinb, prevb;
        int            p, r;
        pad_now = (m_flat_dir() & m_flat_out()) | (ext_en & ext_val);
        p = int'(bus.ADDR[AW-1:3]);
        r = int'(bus.ADDR[2:0]);
        if (bus.RE) exp_rdata = m_read(bus.ADDR);
        exp_rvalid = bus.RE;
        for (int q = 0; q < NP; q++) begin
            pinb  = hist[S-1][q*W +: W];
            prevb = hist[S][q*W +: W];
            setv  = (m_cnt >= S+1) ? ((m_edge[q] & prevb & ~pinb) | (~m_edge[q] & pinb & ~prevb)) : '0;
            clrv  = (bus.WE && p == q && r == 5) ? bus.WDATA : '0;
            m_iflag[q] = (m_iflag[q] & ~clrv) | setv;
        end
        if (bus.WE && p < NP) begin
            case (r)
                0:       m_out[p]  = bus.WDATA;
                1:       m_dir[p]  = bus.WDATA;
                3:       m_ie[p]   = bus.WDATA;
                4:       m_edge[p] = bus.WDATA;
                6:       m_out[p]  = m_out[p] ^ bus.WDATA;
                default: ;
            endcase
        end
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = pad_now;
        if (m_cnt < 1000) m_cnt++;
    endtask

    always @(negedge clk) begin
        check("rvalid", 32'(bus.RVALID), 32'(exp_rvalid));
        check("rdata", 32'(bus.RDATA), 32'(exp_rdata));
        check("irq", 32'(bus.IRQ), 32'(m_irq()));
        check("pad_drive", 32'(pads & m_flat_dir()), 32'(m_flat_out() & m_flat_dir()));
        check("pad_ext", 32'(pads & ext_en & ~m_flat_dir()), 32'(ext_val & ext_en & ~m_flat_dir()));
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int r, input logic [W-1:0] d);
        bus.ADDR  = AW'(p*8 + r);
        bus.WDATA = d;
        bus.WE    = 1'b1;
        tick();
        bus.WE    = 1'b0;
    endtask

    task automatic rd(input int p, input int r, output logic [W-1:0] d);
        bus.ADDR = AW'(p*8 + r);
        bus.RE   = 1'b1;
        tick();
        bus.RE   = 1'b0;
        d        = bus.RDATA;
    endtask

    logic [W-1:0] d;

    initial begin
        bus.ADDR  = '0;
        bus.WDATA = '0;
        bus.WE    = 1'b0;
        bus.RE    = 1'b0;
        ext_en    = '1;
        ext_val   = {NP{8'hA5}};
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Rising edges on port 0 after priming: A5 -> FF sets bits 5A.
        repeat (S+3) tick();
        ext_val[7:0] = 8'hFF;
        repeat (S+3) tick();
        wr(0, 3, 8'hFF);
        check("pre_rst_irq", 32'(bus.IRQ), 32'd1);
        wr(0, 0, 8'h77);
        rd(0, 5, d); check("pre_rst_iflag", 32'(d), 32'h5A);

        // Asynchronous reset in the middle of a read.
        bus.ADDR = AW'(0);
        bus.RE   = 1'b1;
        @(posedge clk);
        model_update();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_rvalid", 32'(bus.RVALID), 32'd0);
        check("rst_rdata", 32'(bus.RDATA), 32'd0);
        check("rst_irq", 32'(bus.IRQ), 32'd0);
        bus.RE = 1'b0;
        @(negedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        repeat (S+3) tick();
        for (int p = 0; p < NP; p++) begin
            for (int r = 0; r < 8; r++) begin
                rd(p, r, d);
                check($sformatf("post_rst_p%0d_r%0d", p, r), 32'(d),
                      (r == 2) ? 32'(ext_val[p*W +: W]) : 32'd0);
            end
        end

        // Port 1: upper nibble driven, lower nibble from outside.
        ext_val[15:8] = 8'h05;
        repeat (S+2) tick();
        wr(1, 1, 8'hF0);
        ext_en[15:12] = 4'h0;
        wr(1, 0, 8'h3C);
        check("p1_drive_hi", 32'(pads[15:12]), 32'h3);
        check("p1_ext_lo", 32'(pads[11:8]), 32'h5);
        repeat (S) tick();
        rd(1, 2, d); check("p1_pin", 32'(d), 32'h35);
        rd(1, 5, d); check("p1_loopback_iflag", 32'(d), 32'h30);

        // Toggle on port 0.
        wr(0, 0, 8'h0F);
        wr(0, 6, 8'hFF);
        rd(0, 0, d); check("toggle1", 32'(d), 32'hF0);
        rd(0, 6, d); check("toggle_reads0", 32'(d), 32'h00);
        wr(0, 6, 8'h01);
        rd(0, 0, d); check("toggle2", 32'(d), 32'hF1);

        // Edge interrupt on port 2 bit 0.
        wr(2, 3, 8'h01);
        ext_val[16] = 1'b0;
        repeat (S+3) tick();
        wr(2, 5, 8'hFF);
        check("irq_idle", 32'(bus.IRQ), 32'd0);
        ext_val[16] = 1'b1;
        repeat (S) tick();
        check("irq_not_yet", 32'(bus.IRQ), 32'd0);
        tick();
        check("irq_rise", 32'(bus.IRQ), 32'd1);
        rd(2, 5, d); check("iflag_rise", 32'(d), 32'h01);
        wr(2, 5, 8'h01);
        check("w1c_clears", 32'(bus.IRQ), 32'd0);
        ext_val[16] = 1'b0;
        repeat (S+3) tick();
        check("fall_ignored", 32'(bus.IRQ), 32'd0);

        // Clear lands on the same edge that detects.
        ext_val[16] = 1'b1;
        repeat (S) tick();
        wr(2, 5, 8'h01);
        check("collision_irq", 32'(bus.IRQ), 32'd1);
        rd(2, 5, d); check("collision_iflag", 32'(d), 32'h01);
        wr(2, 5, 8'h01);
        check("clear_after", 32'(bus.IRQ), 32'd0);

        // Falling-edge mode.
        wr(2, 4, 8'h01);
        ext_val[16] = 1'b0;
        repeat (S+1) tick();
        check("irq_fall", 32'(bus.IRQ), 32'd1);
        wr(2, 5, 8'h01);

        // Unmapped port and reserved offset.
        rd(3, 0, d); check("unmapped_rdata", 32'(d), 32'd0);
        check("unmapped_rvalid", 32'(bus.RVALID), 32'd1);
        rd(0, 7, d); check("reserved_rdata", 32'(d), 32'd0);
        wr(3, 0, 8'hFF);
        wr(0, 7, 8'hFF);
        rd(0, 0, d); check("unmapped_wr_out", 32'(d), 32'hF1);
        rd(0, 1, d); check("unmapped_wr_dir", 32'(d), 32'h00);

        // Simultaneous write and read returns the old value.
        wr(0, 0, 8'h11);
        bus.ADDR  = AW'(0);
        bus.WDATA = 8'h22;
        bus.WE    = 1'b1;
        bus.RE    = 1'b1;
        tick();
        bus.WE    = 1'b0;
        bus.RE    = 1'b0;
        check("rw_old", 32'(bus.RDATA), 32'h11);
        rd(0, 0, d); check("rw_new", 32'(d), 32'h22);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
